// File: rtl/alu_multicycle.sv
// alu_multicycle: execution unit with valid/ready handshakes on both sides.
// ADD/SUB/logic/compare finish in one cycle; UMUL/SMUL run a WIDTH-step
// shift-add engine. Results are 2*WIDTH wide and carry the destination tag.
module alu_multicycle #(
  parameter int WIDTH     = 16,
  parameter int TAG_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [3:0]             iOperation,
  input  logic [WIDTH-1:0]       iA,
  input  logic [WIDTH-1:0]       iB,
  input  logic [TAG_WIDTH-1:0]   iDestination,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [2*WIDTH-1:0]     oResult,
  output logic [TAG_WIDTH-1:0]   oDestination,
  output logic                   oZero,
  output logic                   oCarry,
  output logic                   oError
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} stateType;

  stateType               state, nextState;
  logic [CW-1:0]          counter;
  logic [WIDTH-1:0]       multiplicand;
  logic [2*WIDTH-1:0]     acc;
  logic                   negateResult;

  logic                   accept;
  logic                   isMul;
  logic                   isSigned;
  logic signed [WIDTH-1:0] aSigned;
  logic signed [WIDTH-1:0] bSigned;
  logic [WIDTH-1:0]       magA;
  logic [WIDTH-1:0]       magB;
  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
  logic [2*WIDTH-1:0]     aluResult;
  logic                   aluCarry;
  logic                   aluError;
  logic [WIDTH:0]         partial;
  logic [2*WIDTH-1:0]     stepAcc;
  logic [2*WIDTH-1:0]     product;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is exactly its unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    if (v[WIDTH-1]) return ~v + WIDTH'(1);
    else            return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  assign oReady   = (state == IDLE);
  assign oValid   = (state == DONE);
  assign accept   = iValid && oReady;
  assign isMul    = (iOperation == 4'd6) || (iOperation == 4'd7);
  assign isSigned = (iOperation == 4'd7);
  assign aSigned  = iA;
  assign bSigned  = iB;
  assign magA     = isSigned ? magnitude(aSigned) : iA;
  assign magB     = isSigned ? magnitude(bSigned) : iB;

  // Single-cycle operations, evaluated straight from the request inputs
  always_comb begin
    sum       = {1'b0, iA} + {1'b0, iB};
    diff      = {1'b0, iA} - {1'b0, iB};
    aluResult = '0;
    aluCarry  = 1'b0;
    aluError  = 1'b0;
    case (iOperation)
      4'd0: begin
        aluResult = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        aluCarry  = sum[WIDTH];
      end
      4'd1: begin
        aluResult = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        aluCarry  = diff[WIDTH];
      end
      4'd2: aluResult = {{WIDTH{1'b0}}, iA & iB};
      4'd3: aluResult = {{WIDTH{1'b0}}, iA | iB};
      4'd4: aluResult = {{WIDTH{1'b0}}, iA ^ iB};
      4'd5: aluResult = {{(2*WIDTH-1){1'b0}}, (iA <= iB)};
      4'd6, 4'd7: ;
      default: aluError = 1'b1;
    endcase
  end

  // One shift-add step: the upper half absorbs the multiplicand when the
  // multiplier LSB (acc[0]) is set, then everything shifts right.
  always_comb begin
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? multiplicand : {WIDTH{1'b0}})};
    stepAcc = {partial, acc[WIDTH-1:1]};
    product = negateResult ? negate2w(stepAcc) : stepAcc;
  end

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = isMul ? MUL : DONE;
      MUL:     if (counter == '0) nextState = DONE;
      DONE:    if (iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, multiply iteration and result/flag registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      counter      <= '0;
      multiplicand <= '0;
      acc          <= '0;
      negateResult <= 1'b0;
      oResult      <= '0;
      oDestination <= '0;
      oZero        <= 1'b0;
      oCarry       <= 1'b0;
      oError       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            oDestination <= iDestination;
            if (isMul) begin
              multiplicand <= magA;
              acc          <= {{WIDTH{1'b0}}, magB};
              counter      <= CW'(WIDTH - 1);
              negateResult <= isSigned && (iA[WIDTH-1] ^ iB[WIDTH-1]);
              oCarry       <= 1'b0;
              oError       <= 1'b0;
            end else begin
              oResult <= aluResult;
              oCarry  <= aluCarry;
              oError  <= aluError;
              oZero   <= (aluResult == '0);
            end
          end
        end
        MUL: begin
          acc     <= stepAcc;
          counter <= counter - CW'(1);
          if (counter == '0) begin
            oResult <= product;
            oZero   <= (product == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed, table-driven bench for alu_multicycle plus hand-written
// backpressure and mid-multiply reset sequences.
module tb_alu_multicycle;

  logic        clk;
  logic        rstN;
  logic        iValid;
  logic        oReady;
  logic [3:0]  iOperation;
  logic [15:0] iA;
  logic [15:0] iB;
  logic [7:0]  iDestination;
  logic        oValid;
  logic        iReady;
  logic [31:0] oResult;
  logic [7:0]  oDestination;
  logic        oZero;
  logic        oCarry;
  logic        oError;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  tag;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } vecT;

  vecT vecs[16];

  alu_multicycle #(.WIDTH(16), .TAG_WIDTH(8)) dut (
    .Clock(clk), .Reset(rstN), .iValid(iValid), .oReady(oReady),
    .iOperation(iOperation), .iA(iA), .iB(iB), .iDestination(iDestination),
    .oValid(oValid), .iReady(iReady), .oResult(oResult),
    .oDestination(oDestination), .oZero(oZero), .oCarry(oCarry), .oError(oError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op with iReady high, scramble inputs after accept, wait
  // (bounded) for the result and check result, flags, tag and latency.
  task automatic doOp(input vecT v, input string name);
    int cycles;
    logic busyReady;
    iOperation   = v.op;
    iA           = v.a;
    iB           = v.b;
    iDestination = v.tag;
    iValid       = 1'b1;
    iReady       = 1'b1;
    @(posedge clk); #1;
    iValid       = 1'b0;
    iA           = ~v.a;
    iB           = ~v.b;
    iOperation   = 4'd1;
    iDestination = ~v.tag;
    cycles    = 1;
    busyReady = 1'b0;
    while (!oValid && cycles < 60) begin
      if (oReady) busyReady = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    check({name, "_lat"},  64'(cycles),   64'(v.lat));
    check({name, "_res"},  64'(oResult),  64'(v.res));
    check({name, "_c"},    64'(oCarry),   64'(v.c));
    check({name, "_z"},    64'(oZero),    64'(v.z));
    check({name, "_err"},  64'(oError),   64'(v.e));
    check({name, "_tag"},  64'(oDestination), 64'(v.tag));
    if (v.lat > 1) check({name, "_busyRdy"}, 64'(busyReady), 64'd0);
    @(posedge clk); #1;
    check({name, "_release"}, 64'({oValid, oReady}), 64'b01);
  endtask

  initial begin
    int cycles;
    logic stable;
    logic [31:0] held;

    vecs[0]  = '{4'd0, 16'hFFFF, 16'h0001, 8'h12, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'd1, 16'h0003, 16'h0005, 8'h21, 32'h0000FFFE, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'd2, 16'hF0F0, 16'h3C3C, 8'h33, 32'h00003030, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd3, 16'hF0F0, 16'h0F0F, 8'h44, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'd4, 16'hAAAA, 16'hAAAA, 8'h55, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'd5, 16'h0003, 16'h0005, 8'h66, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd5, 16'h0006, 16'h0005, 8'h67, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{4'd8, 16'h1234, 16'h5678, 8'h77, 32'h00000000, 1'b0, 1'b1, 1'b1, 1};
    vecs[8]  = '{4'd0, 16'h1234, 16'h4321, 8'h88, 32'h00005555, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd1, 16'h0005, 16'h0003, 8'h99, 32'h00000002, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd6, 16'hFFFF, 16'hFFFF, 8'hA0, 32'hFFFE0001, 1'b0, 1'b0, 1'b0, 17};
    vecs[11] = '{4'd6, 16'h0003, 16'h0004, 8'hA1, 32'h0000000C, 1'b0, 1'b0, 1'b0, 17};
    vecs[12] = '{4'd7, 16'h8000, 16'h8000, 8'hB0, 32'h40000000, 1'b0, 1'b0, 1'b0, 17};
    vecs[13] = '{4'd7, 16'hFFFF, 16'h0003, 8'hB1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 17};
    vecs[14] = '{4'd7, 16'h0000, 16'h8000, 8'hB2, 32'h00000000, 1'b0, 1'b1, 1'b0, 17};
    vecs[15] = '{4'd7, 16'h7FFF, 16'h8000, 8'hB3, 32'hC0008000, 1'b0, 1'b0, 1'b0, 17};

    rstN = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iOperation = 4'd0; iA = '0; iB = '0; iDestination = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_result", 64'(oResult), 64'd0);
    check("rst_ready", 64'(oReady), 64'd1);
    rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", 64'(oValid), 64'd0);

    for (int i = 0; i < 16; i++) doOp(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while iReady is low; a request pulsed
    // meanwhile must be ignored.
    iOperation = 4'd6; iA = 16'h1234; iB = 16'h0010; iDestination = 8'hC5;
    iValid = 1'b1; iReady = 1'b0;
    @(posedge clk); #1;
    iValid = 1'b0;
    cycles = 1;
    while (!oValid && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("bp_lat", 64'(cycles), 64'd17);
    check("bp_res", 64'(oResult), 64'h00012340);
    held = oResult;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        iValid = 1'b1; iOperation = 4'd0; iA = 16'h0001; iB = 16'h0001;
      end else begin
        iValid = 1'b0;
      end
      @(posedge clk); #1;
      if (!oValid || oReady || oResult !== held) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    iValid = 1'b0; iReady = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 64'({oValid, oReady}), 64'b01);
    @(posedge clk); #1;
    check("bp_noaccept", 64'(oValid), 64'd0);
    check("bp_keep", 64'(oResult), 64'h00012340);

    // Reset in the 8th cycle of a UMUL discards it and clears outputs.
    iOperation = 4'd6; iA = 16'hFFFF; iB = 16'hFFFF; iDestination = 8'hD7;
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    check("mrst_valid", 64'(oValid), 64'd0);
    check("mrst_result", 64'(oResult), 64'd0);
    check("mrst_ready", 64'(oReady), 64'd1);
    check("mrst_tag", 64'(oDestination), 64'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    check("mrst_novalid", 64'(oValid), 64'd0);
    doOp('{4'd5, 16'h0004, 16'h0004, 8'hE1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1}, "cmple_eq");
    doOp('{4'hF, 16'hFFFF, 16'h0001, 8'hE2, 32'h00000000, 1'b0, 1'b1, 1'b1, 1}, "illegalF");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
